hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core. It is the driver side of the fetch stage's control interface: it generates the active-low PC and fetch/decode enables and the fetch/decode clear.
- It also produces the execute-stage flush, the execute-stage stall and the memory-stage bubble. It sequences multi-cycle execute operations (M-extension multiplier), generates a post-reset pipeline flush, and computes the operand forwarding selects.

Parameters:
MUL_LAT, 4, total cycles a multi-cycle op occupies the execute stage; must be >= 2. With MUL_LAT=1, MulStartE is ignored.
CNT_W, $clog2(MUL_LAT), width of the busy down-counter.

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
Rs1D  in  5  decode-stage source register 1
Rs2D  in  5  decode-stage source register 2
Rs1E  in  5  execute-stage source register 1
Rs2E  in  5  execute-stage source register 2
RdE  in  5  execute-stage destination
RdM  in  5  memory-stage destination
RdW  in  5  writeback-stage destination
LoadE  in  1  execute-stage instruction is a load
RegWriteM  in  1  memory-stage instruction writes the register file
RegWriteW  in  1  writeback-stage instruction writes the register file
PCSrcE  in  1  taken branch or jump resolved in execute
MulStartE  in  1  multi-cycle op present in execute
EN_PC_n  out  1  PC enable, active-low (1 = hold PC)
EN_pipeline_n  out  1  fetch/decode register enable, active-low (1 = hold)
CLR  out  1  synchronous clear of fetch/decode register
FlushE  out  1  bubble into the decode/execute register
StallE  out  1  hold the decode/execute register
FlushM  out  1  bubble into the execute/memory register
ForwardAE  out  2  operand A select: 00 = regfile, 01 = W result, 10 = M ALU result
ForwardBE  out  2  operand B select, same encoding
busy  out  1  multi-cycle op in progress (state == BUSY)

Behaviour:
- States: BOOT, IDLE, BUSY. Reset_n low forces state=BOOT asynchronously, sets cnt=0, and asserts EN_PC_n=1, EN_pipeline_n=1, CLR=1, FlushE=1, FlushM=1, StallE=0, ForwardAE=ForwardBE=00, busy=0.
- BOOT, the first clock after reset release: CLR=1, FlushE=1, FlushM=0, enables active (both _n=0). Unconditional transition to IDLE.
- lwStall = LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- mulStall = (state==IDLE && MulStartE && MUL_LAT>1) || (state==BUSY && cnt!=0).
- Priority in IDLE/BUSY is mulStall > PCSrcE > lwStall. All control outputs are combinational from state and inputs.
  - mulStall: EN_PC_n=1, EN_pipeline_n=1, StallE=1, FlushM=1, FlushE=0, CLR=0.
  - else PCSrcE: CLR=1, FlushE=1, both enables active (PC loads target), StallE=0, FlushM=0.
  - else lwStall: EN_PC_n=1, EN_pipeline_n=1, FlushE=1, CLR=0, StallE=0, FlushM=0. Exactly one bubble per load-use.
  - else: all enables active, all clears/flushes/stalls 0.
- IDLE with MulStartE and MUL_LAT>1: load cnt=MUL_LAT-2, go to BUSY.
- BUSY: cnt!=0 gives stall and decrement. cnt==0 gives no stall; the op completes that cycle and the state goes to IDLE. MulStartE is ignored throughout BUSY, including the final cycle, so the same op is not restarted.
- Execute residency for a multi-cycle op is exactly MUL_LAT cycles; there are MUL_LAT-1 stalled cycles.
- PCSrcE asserted while mulStall is active is ignored; a multi-cycle op is never a branch.
- ForwardAE (combinational, any state except reset):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- x0 is never a hazard source: RdE/RdM/RdW==0 never stalls or forwards.
- Reset asserted mid-BUSY aborts the op; after release the sequence is BOOT then IDLE.

Test Plan:
- Release reset -> cycle 1: CLR=1, FlushE=1, EN_PC_n=0; cycle 2: all controls 0, state IDLE.
- LoadE=1, RdE=5, Rs1D=5 -> one cycle of EN_PC_n=1, EN_pipeline_n=1, FlushE=1; the next cycle has no stall once the load moves to M. Repeat with RdE=0 -> no stall.
- PCSrcE=1 with lwStall also true -> CLR=1, FlushE=1, EN_PC_n=0, EN_pipeline_n=0 (flush wins).
- MUL_LAT=4, MulStartE held high 4 cycles -> StallE=1, FlushM=1, EN_PC_n=1 for exactly 3 cycles; busy=1 for cycles 2-4; 4th cycle unstalled; back to IDLE, no restart.
- Rs1E=7, RdM=7, RegWriteM=1, RdW=7, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> ForwardAE=01. Rs2E=0 with RdW=0 -> ForwardBE=00.
- Assert reset_n=0 during BUSY (cnt=1) -> immediately EN_PC_n=1, CLR=1, FlushM=1, busy=0; after release, BOOT then IDLE, MulStartE low -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencing, multi-cycle execute control and operand forwarding
module hazard_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int CNT_W = $clog2(MUL_LAT)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       LoadE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       PCSrcE,
   input  logic       MulStartE,
   output logic       EN_PC_n,
   output logic       EN_pipeline_n,
   output logic       CLR,
   output logic       FlushE,
   output logic       StallE,
   output logic       FlushM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       busy
);
   localparam int CW = CNT_W < 1 ? 1 : CNT_W;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
   typedef enum logic [1:0] {BOOT, IDLE, BUSY} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic lw_stall, mul_stall, mul_go, run, hold;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= BOOT;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
   always_comb begin
      mul_go = state == IDLE && MulStartE && MUL_LAT > 1;
      mul_stall = mul_go || (state == BUSY && cnt != '0);
      lw_stall = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
      run = reset_n && state != BOOT;
      state_nx = state == BOOT ? IDLE : mul_go ? BUSY : (state == BUSY && cnt != '0) ? BUSY : IDLE;
      cnt_nx = mul_go ? CNT_LOAD : (state == BUSY && cnt != '0) ? cnt - CW'(1) : cnt;
      // the reset values are driven combinationally so they appear as soon as reset_n drops
      hold = !reset_n || (run && (mul_stall || (!PCSrcE && lw_stall)));
      EN_PC_n = hold;
      EN_pipeline_n = hold;
      CLR = !reset_n || state == BOOT || (run && !mul_stall && PCSrcE);
      FlushE = !reset_n || state == BOOT || (run && !mul_stall && (PCSrcE || lw_stall));
      StallE = run && mul_stall;
      FlushM = !reset_n || (run && mul_stall);
      busy = reset_n && state == BUSY;
      ForwardAE = !reset_n ? 2'b00 : (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? 2'b10 :
                  (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? 2'b01 : 2'b00;
      ForwardBE = !reset_n ? 2'b00 : (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? 2'b10 :
                  (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? 2'b01 : 2'b00;
   end
endmodule
